// File: rtl/cpu_trace_pkg.sv
// cpu_trace_pkg: shared state encoding and constants for the UART trace transmitter
package cpu_trace_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam int FRAME_BYTES = 5;
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: single-byte UART serializer (start, 8 data LSB first, optional even parity, stop)
// Ports: Clk, Reset (sync, active-low), Load/Data (byte accepted when idle or on Done),
//        TX (serial line, idle high), Done (high in the last cycle of the stop bit).
// Optional even parity bit under UART_TRACE_PARITY_EN.
module uart_tx_byte
  import cpu_trace_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Load,
  input  logic [7:0] Data,
  output logic       TX,
  output logic       Done
);
  localparam int BW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  state_t state, next;
  logic [BW-1:0] baud;
  logic [2:0] bit_idx;
  logic [7:0] shreg;
  logic tick, take;
`ifdef UART_TRACE_PARITY_EN
  logic par;
`endif
  assign tick = baud == BW'(CLKS_PER_BIT - 1);
  assign Done = state == STOP && tick;
  // a byte loaded in the final stop cycle starts with no gap
  assign take = Load && (state == IDLE || Done);
`ifdef UART_TRACE_PARITY_EN
  assign TX = state == START ? 1'b0 : state == DATA ? shreg[0] : state == PARITY ? par : 1'b1;
`else
  assign TX = state == START ? 1'b0 : state == DATA ? shreg[0] : 1'b1;
`endif
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = take ? START : IDLE;
      START:   next = tick ? DATA : START;
`ifdef UART_TRACE_PARITY_EN
      DATA:    next = tick && bit_idx == 3'd7 ? PARITY : DATA;
      PARITY:  next = tick ? STOP : PARITY;
`else
      DATA:    next = tick && bit_idx == 3'd7 ? STOP : DATA;
`endif
      STOP:    next = tick ? (take ? START : IDLE) : STOP;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state <= next;
      baud  <= state == IDLE || tick ? '0 : baud + 1'b1;
      if (take) shreg <= Data;
      else if (state == DATA && tick) shreg <= shreg >> 1;
      if (state == DATA && tick) bit_idx <= bit_idx + 1'b1;
    end
  end
`ifdef UART_TRACE_PARITY_EN
  // parity taken at load time since the shift register consumes the data
  always_ff @(posedge Clk) begin
    if (!Reset) par <= 1'b0;
    else if (take) par <= ^Data;
  end
`endif
endmodule

// File: rtl/uart_trace_tx.sv
// uart_trace_tx: sends a 5-byte CPU state snapshot (sync, PC, instruction, acc, mem) over UART
// Ports: Clk, Reset (sync, active-low), Start (frame request), Program_counter/Instruction/Acc/Mem
//        (snapshot inputs), TX (serial out), Busy (frame in flight), Dropped (Start seen while Busy).
// Optional even parity bit per byte under UART_TRACE_PARITY_EN.
module uart_trace_tx
  import cpu_trace_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 868,
  parameter logic [7:0]  SYNC_BYTE    = SYNC_DEFAULT
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic [4:0] Program_counter,
  input  logic [7:0] Instruction,
  input  logic [7:0] Acc,
  input  logic [7:0] Mem,
  output logic       TX,
  output logic       Busy,
  output logic       Dropped
);
  logic [31:0] snap;
  logic [2:0] byte_idx;
  logic accept, done, load, last;
  logic [7:0] data;
  assign accept = Start && !Busy;
  assign last = byte_idx == 3'(FRAME_BYTES - 1);
  assign load = accept || (done && !last);
  // when idle the sync byte goes out on accept; otherwise the next snapshot byte follows byte_idx
  assign data = !Busy ? SYNC_BYTE :
                byte_idx == 3'd0 ? snap[31:24] :
                byte_idx == 3'd1 ? snap[23:16] :
                byte_idx == 3'd2 ? snap[15:8] : snap[7:0];
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      Busy     <= 1'b0;
      Dropped  <= 1'b0;
      byte_idx <= '0;
      snap     <= '0;
    end else begin
      Dropped <= Start && Busy;
      if (accept) begin
        Busy     <= 1'b1;
        byte_idx <= '0;
        snap     <= {3'b000, Program_counter, Instruction, Acc, Mem};
      end else if (done) begin
        Busy     <= !last;
        byte_idx <= last ? '0 : byte_idx + 1'b1;
      end
    end
  end
  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
    .Clk  (Clk),
    .Reset(Reset),
    .Load (load),
    .Data (data),
    .TX   (TX),
    .Done (done)
  );
endmodule

// File: tb/tb_uart_trace_tx.sv
// tb_uart_trace_tx: model-checked directed bench for uart_trace_tx
module tb_uart_trace_tx;
  localparam int CPB = 4;
`ifdef UART_TRACE_PARITY_EN
  localparam int BPB = 11;
  localparam logic [7:0] ACC_V = 8'h07;
`else
  localparam int BPB = 10;
  localparam logic [7:0] ACC_V = 8'h7F;
`endif
  localparam int FC = 5 * BPB * CPB;
  logic Clk, Reset, Start, TX, Busy, Dropped;
  logic [4:0] Program_counter;
  logic [7:0] Instruction, Acc, Mem;
  uart_trace_tx #(.CLKS_PER_BIT(CPB)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Program_counter(Program_counter),
    .Instruction(Instruction), .Acc(Acc), .Mem(Mem), .TX(TX), .Busy(Busy), .Dropped(Dropped)
  );
  initial Clk = 0;
  always #5 Clk = ~Clk;
  int n_chk = 0, n_fail = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // model: queue of per-cycle expected line levels for the frame in flight
  logic q[$];
  logic m_drop = 0;
  bit chk_en = 0;
  always @(posedge Clk) begin : model
    logic [7:0] fb [5];
    bit was;
    was = q.size() != 0;
    if (!Reset) begin
      q.delete();
      m_drop = 0;
    end else begin
      m_drop = Start && was;
      if (was) void'(q.pop_front());
      else if (Start) begin
        fb = '{8'hA5, {3'b000, Program_counter}, Instruction, Acc, Mem};
        foreach (fb[j])
          for (int k = 0; k < BPB; k++)
            for (int c = 0; c < CPB; c++)
              q.push_back(k == 0 ? 1'b0 : k <= 8 ? fb[j][k-1] : (BPB == 11 && k == 9) ? ^fb[j] : 1'b1);
      end
    end
  end
  always @(negedge Clk) begin
    if (chk_en) begin
      chk("tx", TX, q.size() != 0 ? q[0] : 1'b1);
      chk("busy", Busy, q.size() != 0);
      chk("dropped", Dropped, m_drop);
    end
  end
  logic samp [300];
  logic dsamp [300];
  logic bz [3*(FC+1)];
  logic [7:0] exp_b [5] = '{8'hA5, 8'h03, 8'h2B, ACC_V, 8'h00};
  logic a5_bits [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
  task automatic set_inputs();
    Program_counter = 5'd3;
    Instruction = 8'h2B;
    Acc = ACC_V;
    Mem = 8'h00;
  endtask
  task automatic capture(input int chg_at, input int drop_at, input int rst_at, output int n);
    Start = 1;
    @(negedge Clk);
    Start = 0;
    n = 0;
    while (Busy && n < 300) begin
      samp[n] = TX;
      dsamp[n] = Dropped;
      if (n == chg_at) begin
        Program_counter = '1;
        Instruction = '1;
        Acc = '1;
        Mem = '1;
      end
      Start = n == drop_at;
      if (n == rst_at) Reset = 0;
      @(negedge Clk);
      n++;
    end
    Reset = 1;
    Start = 0;
    chk("capture_bound", n < 300, 1);
  endtask
  function automatic logic [7:0] dec(input int j);
    logic [7:0] d;
    for (int k = 0; k < 8; k++) d[k] = samp[j*BPB*CPB + (1+k)*CPB + CPB/2];
    return d;
  endfunction
  task automatic check_frame(input string tag);
    for (int j = 0; j < 5; j++) chk($sformatf("%s_byte%0d", tag, j), dec(j), exp_b[j]);
  endtask
  initial begin
    int n, w;
    Reset = 0;
    Start = 0;
    Program_counter = 0;
    Instruction = 0;
    Acc = 0;
    Mem = 0;
    repeat (3) @(negedge Clk);
    chk("reset_tx", TX, 1);
    chk("reset_busy", Busy, 0);
    chk("reset_dropped", Dropped, 0);
    chk_en = 1;
    Reset = 1;
    @(negedge Clk);
    set_inputs();
    capture(-1, -1, -1, n);
    chk("t1_len", n, FC);
    for (int k = 0; k < 8; k++) chk($sformatf("t1_sync_bit%0d", k), samp[(1+k)*CPB], a5_bits[k]);
    check_frame("t1");
`ifdef UART_TRACE_PARITY_EN
    chk("t1_par_a5", samp[9*CPB + CPB/2], 0);
    chk("t1_par_07", samp[3*BPB*CPB + 9*CPB + CPB/2], 1);
`endif
    capture(0, -1, -1, n);
    chk("t2_len", n, FC);
    check_frame("t2");
    set_inputs();
    @(negedge Clk);
    capture(-1, 30, -1, n);
    chk("t3_len", n, FC);
    chk("t3_drop30", dsamp[30], 0);
    chk("t3_drop31", dsamp[31], 1);
    chk("t3_drop32", dsamp[32], 0);
    check_frame("t3");
    capture(-1, -1, 50, n);
    chk("t4_abort_len", n, 51);
    chk("t4_abort_tx", TX, 1);
    chk("t4_abort_busy", Busy, 0);
    @(negedge Clk);
    capture(-1, -1, -1, n);
    chk("t4_len", n, FC);
    check_frame("t4");
    Start = 1;
    for (int i = 0; i < 3*(FC+1); i++) begin
      @(negedge Clk);
      bz[i] = Busy;
    end
    Start = 0;
    for (int f = 0; f < 3; f++) begin
      chk($sformatf("t5_busy_end%0d", f), bz[f*(FC+1) + FC - 1], 1);
      chk($sformatf("t5_gap%0d", f), bz[f*(FC+1) + FC], 0);
    end
    w = 0;
    while (Busy && w < 300) begin
      @(negedge Clk);
      w++;
    end
    chk("t5_drain", w < 300, 1);
    repeat (2) @(negedge Clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/uart_trace_tx.md
# uart_trace_tx

Serial trace transmitter for the 8-bit CPU: the outbound counterpart of the UART instruction-load receiver on `RX`. On a `Start` request it snapshots the CPU's visible state (program counter, instruction, accumulator, data-memory output) and sends it as a fixed 5-byte frame on `TX` (8N1, LSB first) for a host-side monitor. It sits beside the CPU top level and consumes the CPU's existing debug outputs unchanged.

## Interface

- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200); legal range ≥ 2.
- `SYNC_BYTE`, default 8'hA5: first byte of every frame.
- `Clk`  in  1  system clock; all logic on the rising edge.
- `Reset`  in  1  synchronous, active-low reset (0 = reset).
- `Start`  in  1  level request to send one frame; sampled only in IDLE.
- `Program_counter`  in  5  CPU PC, captured on frame accept.
- `Instruction`  in  8  `{opcode, address}`, captured on frame accept.
- `Acc`  in  8  accumulator, captured on frame accept.
- `Mem`  in  8  data-memory output, captured on frame accept.
- `TX`  out  1  serial line; idle high.
- `Busy`  out  1  high from accept until the final stop bit completes.
- `Dropped`  out  1  one-cycle pulse per cycle a `Start` is seen while `Busy`.

## Operation

- Frame bytes, in order: `SYNC_BYTE`, `{3'b000, Program_counter}`, `Instruction`, `Acc`, `Mem`.
- All four inputs are latched into a 32-bit snapshot register in the accept cycle; later input changes do not affect the frame in flight.
- Per byte: start bit (0), data bits 0..7 LSB first, optional parity bit (see Configuration), stop bit (1).
- States: IDLE → START → DATA → [PARITY] → STOP → START (next byte) or IDLE (after byte 4).
- Counters: baud counter 0..CLKS_PER_BIT-1, bit index 0..7, byte index 0..4; each wraps to 0 on advance.
- No inter-byte gap: the stop bit of byte *n* is followed immediately by the start bit of byte *n*+1.
- `Start` while not IDLE is ignored; `Dropped` is asserted on the next edge for one cycle.

## Timing

- Reset (Reset = 0 at a rising edge): `TX` = 1, `Busy` = 0, `Dropped` = 0, state IDLE, all counters 0; takes effect from that edge, including mid-frame (frame aborted; no partial-byte completion).
- Accept: `Start` = 1 in IDLE at edge *t* → from edge *t* onward `Busy` = 1 and `TX` = 0 (start bit).
- Each bit holds for exactly `CLKS_PER_BIT` cycles.
- Frame length: 50 × `CLKS_PER_BIT` cycles (55 × with parity); `Busy` falls at the edge ending the last stop bit and `TX` stays 1.
- Back-to-back: the earliest re-accept is the edge after `Busy` falls, giving exactly one idle-high cycle between frames when `Start` is held.
- `Dropped` is registered: high in the cycle after each cycle in which `Start` = 1 and `Busy` = 1.

## Configuration

- `UART_TRACE_PARITY_EN` defined: an even-parity bit (XOR of the 8 data bits) is inserted between bit 7 and stop; 11 bits per byte.
- Not defined: no PARITY state, 10 bits per byte, 8N1.

## Structure

- Package `cpu_trace_pkg`: state enum (IDLE, START, DATA, PARITY, STOP), `FRAME_BYTES` = 5, default `SYNC_BYTE`.
- Sub-module `uart_tx_byte`: single-byte serializer (baud counter, bit counter, shift register, parity) with `Load`/`Done` handshake. The top level holds the snapshot, byte sequencer, `Busy`, and `Dropped`.

## Test plan

- `CLKS_PER_BIT` = 4, PC = 5'd3, Instruction = 8'h2B, Acc = 8'h7F, Mem = 8'h00, one `Start` pulse → `TX` decodes to A5, 03, 2B, 7F, 00; `Busy` high for exactly 200 cycles; first data bits after start are 1,0,1,0,0,1,0,1.
- Change all inputs to 8'hFF one cycle after accept → transmitted frame is still A5, 03, 2B, 7F, 00.
- `Start` pulsed at cycle 30 of a frame → `Dropped` high for one cycle at cycle 31; frame contents and length unchanged.
- `Reset` = 0 at cycle 50 of a frame → `TX` = 1, `Busy` = 0 from that edge; a new `Start` after release sends a complete, correct frame.
- `Start` held high for 3 frames → three identical frames, each followed by exactly one idle-high cycle with `Busy` = 0.
- With `UART_TRACE_PARITY_EN`, Acc = 8'h07 → parity bit 1 for byte 07, 0 for A5; frame lasts 220 cycles.
